// File: rtl/ctl_round_if.sv
`timescale 1ns/1ps
// ctl_round_if
// Bundles the game-control inputs and the sequencer outputs of ctl_round.
//   master : the side that drives the game events (frame tick, start, pause,
//            hit, no_ammo, duck_show) and observes the sequencer outputs.
//   slave  : ctl_round itself.
// Signals:
//   new_frame   1  pulse per VGA frame
//   start       1  pulse, starts/restarts the game
//   pause       1  level, freezes timers and masks hit
//   hit         1  pulse from the trigger logic
//   no_ammo     1  level from the ammo counter
//   duck_show   1  level, duck still on screen
//   duck_launch 1  pulse, new flight
//   duck_escape 1  pulse, duck flew away unhit
//   round_ducks 4  ducks launched this round
//   round_hits  4  ducks hit this round
//   level       4  current level
//   h_speed     6  horizontal duck speed for the current level
//   game_over   1  high while in GAME_OVER
//   state_o     3  encoded sequencer state
interface ctl_round_if;
  logic       new_frame;
  logic       start;
  logic       pause;
  logic       hit;
  logic       no_ammo;
  logic       duck_show;
  logic       duck_launch;
  logic       duck_escape;
  logic [3:0] round_ducks;
  logic [3:0] round_hits;
  logic [3:0] level;
  logic [5:0] h_speed;
  logic       game_over;
  logic [2:0] state_o;

  modport master (
    output new_frame, start, pause, hit, no_ammo, duck_show,
    input  duck_launch, duck_escape, round_ducks, round_hits, level,
           h_speed, game_over, state_o
  );

  modport slave (
    input  new_frame, start, pause, hit, no_ammo, duck_show,
    output duck_launch, duck_escape, round_ducks, round_hits, level,
           h_speed, game_over, state_o
  );
endinterface

// File: rtl/ctl_round.sv
`timescale 1ns/1ps
// ctl_round
// Round/level sequencer for Duck Hunt. Issues one launch pulse per duck,
// times escapes, counts launches and hits per round, and at round end either
// advances the level or declares game over. All outputs are registered.
// Ports:
//   i_clk    1  system clock
//   i_rst_n  1  asynchronous reset, active-low
//   bus         ctl_round_if.slave (game events in, sequencer outputs out)
module ctl_round #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int HITS_TO_PASS    = 6,
  parameter int ESCAPE_FRAMES   = 300,
  parameter int PAUSE_FRAMES    = 120,
  parameter int MAX_LEVEL       = 15,
  parameter int BASE_H_SPEED    = 10,
  parameter int H_SPEED_STEP    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  ctl_round_if.slave  bus
);

  localparam int TW = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_FLIGHT    = 3'd2,
    S_FALLING   = 3'd3,
    S_INTER     = 3'd4,
    S_RESULT    = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  // Speed for a given level, clamped to the 6-bit output range.
  function automatic logic [5:0] speed_of(input logic [3:0] lvl);
    int s;
    s = BASE_H_SPEED + int'(lvl) * H_SPEED_STEP;
    if (s > 63) s = 63;
    return 6'(s);
  endfunction

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_round_ducks;
  logic [3:0]    r_round_hits;
  logic [3:0]    r_level;
  logic [5:0]    r_h_speed;
  logic          r_duck_launch;
  logic          r_duck_escape;
  logic          r_game_over;

  // Only frames and hits outside pause are counted.
  logic w_frame;
  logic w_hit;
  assign w_frame = bus.new_frame && !bus.pause;
  assign w_hit   = bus.hit && !bus.pause;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_round_ducks <= '0;
      r_round_hits  <= '0;
      r_level       <= '0;
      r_h_speed     <= speed_of(4'd0);
      r_duck_launch <= 1'b0;
      r_duck_escape <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_duck_launch <= 1'b0;
      r_duck_escape <= 1'b0;
      // Follows level one cycle later.
      r_h_speed     <= speed_of(r_level);

      if (bus.start) begin
        r_state       <= S_LAUNCH;
        r_duck_launch <= 1'b1;
        r_level       <= '0;
        r_round_ducks <= '0;
        r_round_hits  <= '0;
        r_timer       <= '0;
        r_game_over   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;

          // The launch pulse is raised on entry; the duck is counted on exit,
          // so counters read 0 during the first LAUNCH of a round.
          S_LAUNCH: begin
            r_round_ducks <= r_round_ducks + 4'd1;
            r_timer       <= '0;
            r_state       <= S_FLIGHT;
          end

          // Hit has priority over both the timeout and the out-of-ammo escape.
          S_FLIGHT: begin
            if (w_hit) begin
              r_round_hits <= r_round_hits + 4'd1;
              r_state      <= S_FALLING;
            end else if (bus.no_ammo) begin
              r_duck_escape <= 1'b1;
              r_timer       <= '0;
              r_state       <= S_INTER;
            end else if (w_frame) begin
              if (r_timer == TW'(ESCAPE_FRAMES - 1)) begin
                r_duck_escape <= 1'b1;
                r_timer       <= '0;
                r_state       <= S_INTER;
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
          end

          S_FALLING: begin
            if (!bus.duck_show) begin
              r_timer <= '0;
              r_state <= S_INTER;
            end
          end

          S_INTER: begin
            if (w_frame) begin
              if (r_timer == TW'(PAUSE_FRAMES - 1)) begin
                r_timer <= '0;
                if (r_round_ducks < 4'(DUCKS_PER_ROUND)) begin
                  r_state       <= S_LAUNCH;
                  r_duck_launch <= 1'b1;
                end else begin
                  r_state <= S_RESULT;
                end
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
          end

          S_RESULT: begin
            if (r_round_hits >= 4'(HITS_TO_PASS)) begin
              if (r_level < 4'(MAX_LEVEL)) r_level <= r_level + 4'd1;
              r_round_ducks <= '0;
              r_round_hits  <= '0;
              r_state       <= S_LAUNCH;
              r_duck_launch <= 1'b1;
            end else begin
              r_state     <= S_GAME_OVER;
              r_game_over <= 1'b1;
            end
          end

          S_GAME_OVER: ;

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.duck_launch = r_duck_launch;
  assign bus.duck_escape = r_duck_escape;
  assign bus.round_ducks = r_round_ducks;
  assign bus.round_hits  = r_round_hits;
  assign bus.level       = r_level;
  assign bus.h_speed     = r_h_speed;
  assign bus.game_over   = r_game_over;
  assign bus.state_o     = r_state;

endmodule
